// File: rtl/uart_tx_param_if.sv
// rtl/uart_tx_param_if.sv - start/data/status handshake between a frame source and uart_tx_param
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 startSignal;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output startSignal,
    output tx_data,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  startSignal,
    input  tx_data,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity, 1-2 stop bits
module uart_tx_param #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_param_if.slave  bus,
  output logic            txd
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W    = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_MODE < 0 || PARITY_MODE > 2 || BAUD_DIV < 2) begin : g_bad_params
      $error("uart_tx_param: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit;
  logic                 busy_q;
  logic                 done_q;

  wire bit_end = (baud_cnt == CNT_W'(BAUD_DIV - 1));

  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      txd        <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          txd      <= 1'b1;
          busy_q   <= 1'b0;
          baud_cnt <= '0;
          if (bus.startSignal) begin
            shift_reg  <= bus.tx_data;
            // Odd parity is the inverted XOR so the total count of ones comes out odd.
            parity_bit <= (PARITY_MODE == 1) ? ~(^bus.tx_data) : ^bus.tx_data;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            txd        <= 1'b0;
            busy_q     <= 1'b1;
            state      <= START;
          end
        end

        default: begin
          if (!bit_end) begin
            baud_cnt <= baud_cnt + 1'b1;
          end else begin
            baud_cnt <= '0;
            case (state)
              START: begin
                txd   <= shift_reg[0];
                state <= DATA;
              end
              DATA: begin
                if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                  if (PARITY_MODE != 0) begin
                    txd   <= parity_bit;
                    state <= PARITY;
                  end else begin
                    txd   <= 1'b1;
                    state <= STOP;
                  end
                end else begin
                  bit_cnt   <= bit_cnt + 1'b1;
                  shift_reg <= shift_reg >> 1;
                  txd       <= shift_reg[1];
                end
              end
              PARITY: begin
                txd   <= 1'b1;
                state <= STOP;
              end
              default: begin
                if (stop_cnt == 1'(STOP_BITS - 1)) begin
                  txd    <= 1'b1;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= IDLE;
                end else begin
                  stop_cnt <= 1'b1;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - self-checking bench for uart_tx_param across 8N1, 8E1, 8O1 and 7N2 builds
module tb_uart_tx_param;

  localparam int DIV = 10;

  logic       clk;
  logic       reset;
  logic [3:0] start;
  logic [8:0] dat [4];

  logic t0, t1, t2, t3;
  logic [3:0] txd_v, busy_v, done_v;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_param_if #(.DATA_BITS(8)) if0 ();
  uart_tx_param_if #(.DATA_BITS(8)) if1 ();
  uart_tx_param_if #(.DATA_BITS(8)) if2 ();
  uart_tx_param_if #(.DATA_BITS(7)) if3 ();

  assign if0.startSignal = start[0];
  assign if1.startSignal = start[1];
  assign if2.startSignal = start[2];
  assign if3.startSignal = start[3];
  assign if0.tx_data = dat[0][7:0];
  assign if1.tx_data = dat[1][7:0];
  assign if2.tx_data = dat[2][7:0];
  assign if3.tx_data = dat[3][6:0];

  assign txd_v  = {t3, t2, t1, t0};
  assign busy_v = {if3.tx_busy, if2.tx_busy, if1.tx_busy, if0.tx_busy};
  assign done_v = {if3.tx_done, if2.tx_done, if1.tx_done, if0.tx_done};

  uart_tx_param #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1))
    u_8n1 (.clk(clk), .reset(reset), .bus(if0.slave), .txd(t0));
  uart_tx_param #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1))
    u_8e1 (.clk(clk), .reset(reset), .bus(if1.slave), .txd(t1));
  uart_tx_param #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1))
    u_8o1 (.clk(clk), .reset(reset), .bus(if2.slave), .txd(t2));
  uart_tx_param #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2))
    u_7n2 (.clk(clk), .reset(reset), .bus(if3.slave), .txd(t3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame model: line level for every bit time, built straight from the framing rules.
  int cfg_db [4] = '{8, 8, 8, 7};
  int cfg_pm [4] = '{0, 2, 1, 0};
  int cfg_sb [4] = '{1, 1, 1, 2};

  function automatic logic [15:0] make_frame(input logic [8:0] d, input int nb, input int pm);
    logic [15:0] f;
    int ones;
    f = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int j = 0; j < nb; j++) begin
      f[1+j] = d[j];
      ones += int'(d[j]);
    end
    if (pm == 2) f[1+nb] = ((ones % 2) == 1);
    if (pm == 1) f[1+nb] = ((ones % 2) == 0);
    return f;
  endfunction

  logic        m_act  [4];
  logic        m_done [4];
  int          m_cnt  [4];
  int          m_len  [4];
  logic [15:0] m_frame[4];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        m_act[i]  <= 1'b0;
        m_done[i] <= 1'b0;
        m_cnt[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        m_done[i] <= 1'b0;
        if (m_act[i]) begin
          m_cnt[i] <= m_cnt[i] + 1;
          if (m_cnt[i] + 1 == m_len[i]) begin
            m_act[i]  <= 1'b0;
            m_done[i] <= 1'b1;
          end
        end else if (start[i]) begin
          m_act[i]   <= 1'b1;
          m_cnt[i]   <= 0;
          m_frame[i] <= make_frame(dat[i], cfg_db[i], cfg_pm[i]);
          m_len[i]   <= DIV * (1 + cfg_db[i] + ((cfg_pm[i] != 0) ? 1 : 0) + cfg_sb[i]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_frame(input int i, input logic [8:0] d, input bit poke,
                           output int busy_n, output int done_n, output int done_at,
                           output logic [15:0] bits);
    @(negedge clk);
    dat[i]   = d;
    start[i] = 1'b1;
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    bits    = '1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (busy_v[i]) busy_n++;
      if (done_v[i]) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      if ((c % DIV) == 5 && (c / DIV) < 16) bits[c/DIV] = txd_v[i];
      if (c == 0) start[i] = 1'b0;
      if (poke && c == 20) begin
        start[i] = 1'b1;
        dat[i]   = 9'h0FF;
      end
      if (poke && c == 21) start[i] = 1'b0;
    end
  endtask

  initial begin
    int busy_n, done_n, done_at, low_n;
    int d_at [3];
    logic [15:0] bits;

    reset = 1'b0;
    start = '0;
    for (int i = 0; i < 4; i++) dat[i] = '0;

    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          logic [2:0] got, want;
          got  = {txd_v[i], busy_v[i], done_v[i]};
          want = {m_act[i] ? m_frame[i][m_cnt[i] / DIV] : 1'b1, m_act[i], m_done[i]};
          n_checks++;
          if (got !== want) begin
            n_errors++;
            $display("FAIL model dut%0d t=%0t txd/busy/done got %b want %b", i, $time, got, want);
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("reset_txd", 32'(txd_v), 32'hF);
    chk("reset_busy", 32'(busy_v), 32'h0);
    chk("reset_done", 32'(done_v), 32'h0);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(0, 9'h0A3, 1'b0, busy_n, done_n, done_at, bits);
    chk("8n1_bits", 32'(bits), 32'hFF46);
    chk("8n1_busy_len", 32'(busy_n), 32'd100);
    chk("8n1_done_cnt", 32'(done_n), 32'd1);
    chk("8n1_done_at", 32'(done_at), 32'd100);

    run_frame(1, 9'h0A3, 1'b0, busy_n, done_n, done_at, bits);
    chk("8e1_bits", 32'(bits), 32'hFD46);
    chk("8e1_parity", 32'(bits[9]), 32'd0);
    chk("8e1_busy_len", 32'(busy_n), 32'd110);
    chk("8e1_done_at", 32'(done_at), 32'd110);

    run_frame(2, 9'h0A3, 1'b0, busy_n, done_n, done_at, bits);
    chk("8o1_bits", 32'(bits), 32'hFF46);
    chk("8o1_parity", 32'(bits[9]), 32'd1);
    chk("8o1_busy_len", 32'(busy_n), 32'd110);

    run_frame(3, 9'h055, 1'b0, busy_n, done_n, done_at, bits);
    chk("7n2_bits", 32'(bits), 32'hFFAA);
    chk("7n2_stop_bits", 32'(bits[9:8]), 32'h3);
    chk("7n2_busy_len", 32'(busy_n), 32'd100);
    chk("7n2_done_at", 32'(done_at), 32'd100);

    run_frame(0, 9'h0A3, 1'b1, busy_n, done_n, done_at, bits);
    chk("ignore_bits", 32'(bits), 32'hFF46);
    chk("ignore_busy_len", 32'(busy_n), 32'd100);
    chk("ignore_done_cnt", 32'(done_n), 32'd1);

    // Start held high: frames follow each other with exactly one idle clock between.
    @(negedge clk);
    dat[0]   = 9'h0A3;
    start[0] = 1'b1;
    busy_n = 0;
    done_n = 0;
    for (int k = 0; k < 3; k++) d_at[k] = -1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (busy_v[0]) busy_n++;
      if (done_v[0]) begin
        if (done_n < 3) d_at[done_n] = c;
        done_n++;
      end
      if (c == 302) start[0] = 1'b0;
    end
    chk("b2b_done_cnt", 32'(done_n), 32'd3);
    chk("b2b_done0", 32'(d_at[0]), 32'd100);
    chk("b2b_done1", 32'(d_at[1]), 32'd201);
    chk("b2b_done2", 32'(d_at[2]), 32'd302);
    chk("b2b_busy_len", 32'(busy_n), 32'd300);

    @(negedge clk);
    dat[0]   = 9'h0A3;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (45) @(negedge clk);
    chk("pre_reset_busy", 32'(busy_v[0]), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_txd", 32'(txd_v[0]), 32'd1);
    chk("async_busy", 32'(busy_v[0]), 32'd0);
    chk("async_done", 32'(done_v[0]), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    busy_n = 0;
    low_n  = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (busy_v[0]) busy_n++;
      if (!txd_v[0]) low_n++;
    end
    chk("post_reset_busy", 32'(busy_n), 32'd0);
    chk("post_reset_txd_low", 32'(low_n), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised successor to the fixed 8N1 UART transmitter used by top_uart.
- Serialises one word per accepted start request onto txd.
- Configurable baud divisor, data width (5-9), parity mode and stop-bit count.
- Adds busy/done status so an upstream FSM or FIFO can stream frames. Sits between the command/data source and the board TX pin.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate. BAUD_DIV = CLK_FREQ/BAUD_RATE (integer division), clocks per bit, must be >= 2.
- DATA_BITS, 8: payload width, legal 5..9.
- PARITY_MODE, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: legal 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low. Active when 0.
- startSignal  in  1  request to send, level-sampled.
- tx_data  in  DATA_BITS  payload, captured on acceptance.
- txd  out  1  serial line, idle high.
- tx_busy  out  1  frame in progress.
- tx_done  out  1  one-clock pulse at frame end.

Behaviour:
- Reset (async assert, sync release): state IDLE, txd=1, tx_busy=0, tx_done=0, counters=0, shift register=0.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- Acceptance: in IDLE, if startSignal=1 at a rising edge, latch tx_data, compute parity, and go to START. tx_busy=1 and txd=0 from that edge.
- startSignal is ignored in every non-IDLE state. tx_data changes after acceptance have no effect.
- Bit timing: baud counter 0..BAUD_DIV-1, width $clog2(BAUD_DIV). Each bit lasts exactly BAUD_DIV clocks. The counter clears on every bit boundary and on acceptance.
- START: txd=0 for 1 bit, then DATA.
- DATA: DATA_BITS bits, LSB first. Bit counter counts 0..DATA_BITS-1. After the last bit, go to PARITY if PARITY_MODE!=0, else STOP.
- PARITY bit:
  - even: XOR of data, so total ones incl. parity is even.
  - odd: inverted XOR.
  - Computed on latched data.
- STOP: txd=1 for STOP_BITS bits.
- Frame end: at the end of the last stop bit, go to IDLE, tx_busy=0, tx_done=1 for exactly one clock.
- Frame length: tx_busy high for BAUD_DIV*(1+DATA_BITS+P+STOP_BITS) clocks, where P=1 if parity is enabled.
- Back-to-back: if startSignal is held high, the next frame is accepted on the first clock in IDLE. Minimum gap is 1 clock of txd=1 beyond the stop bits.
- Reset mid-frame: txd returns to 1 immediately (async), busy/done clear, and the frame is abandoned. No resume after release.
- Unused upper bits do not exist: tx_data is exactly DATA_BITS wide.
- Illegal parameters (DATA_BITS outside 5..9, STOP_BITS not in {1,2}, PARITY_MODE>2, BAUD_DIV<2) are caught by a generate-time $error.

Test Plan:
- CLK_FREQ=100, BAUD_RATE=10 (DIV=10), 8N1, tx_data=8'hA3, one-cycle startSignal -> txd sequence 0,1,1,0,0,0,1,0,1,1, each held 10 clocks; tx_busy high 100 clocks; single tx_done pulse at cycle 100 after acceptance.
- Same stimulus, PARITY_MODE=2 -> parity bit 0, busy 110 clocks. PARITY_MODE=1 -> parity bit 1.
- DATA_BITS=7, STOP_BITS=2, tx_data=7'h55 -> 0,1,0,1,0,1,0,1,1,1; busy 100 clocks; txd high during both stop bits.
- startSignal pulsed mid-frame and tx_data changed to 8'hFF after acceptance -> ignored; frame still carries 8'hA3.
- startSignal held high for 3 frames -> three identical frames, each separated by exactly 1 idle clock; 3 tx_done pulses.
- reset driven 0 at clock 45 of a frame -> txd=1, tx_busy=0 within the same cycle (async). After release with startSignal=0, the line stays idle.
